// File: rtl/decoder_scan_n.sv
// Registered N-to-2^N one-hot decoder: either decodes sel directly or auto-scans
// the active line through 0..last with a programmable dwell per line.
module decoder_scan_n #(
    parameter int N          = 4,
    parameter int DWELL      = 4,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [N-1:0]        sel,
    input  logic                sel_valid,
    input  logic [N-1:0]        last,
    output logic [(1<<N)-1:0]   y,
    output logic [N-1:0]        idx,
    output logic                wrap
);

    localparam int W  = 1 << N;
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);
    localparam logic [N-1:0]  IDX_ZERO = N'(0);
    localparam logic [N-1:0]  IDX_ONE  = N'(1);
    localparam logic [W-1:0]  LINE_ONE = W'(1);
    localparam logic [W-1:0]  INACTIVE = (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};

    logic [N-1:0]  idx_r;
    logic [CW-1:0] cnt_r;
    logic [W-1:0]  y_r;
    logic          wrap_r;

    logic [N-1:0]  nidx_s;
    logic [CW-1:0] ncnt_s;
    logic          nwrap_s;

    // One line active, polarity applied by XOR with the inactive pattern.
    function automatic logic [W-1:0] decode_line(input logic [N-1:0] line);
        return (LINE_ONE << line) ^ INACTIVE;
    endfunction

    // Next index / dwell / wrap selection; sel_valid outranks the scan.
    always_comb begin
        nidx_s  = idx_r;
        ncnt_s  = cnt_r;
        nwrap_s = 1'b0;
        if (sel_valid) begin
            nidx_s = sel;
            ncnt_s = CNT_ZERO;
        end else if (mode) begin
            if (cnt_r == CNT_LAST) begin
                ncnt_s = CNT_ZERO;
                // Wrap check first so idx+1 can never overflow, and a shrunk last wraps early.
                if (idx_r >= last) begin
                    nidx_s  = IDX_ZERO;
                    nwrap_s = 1'b1;
                end else begin
                    nidx_s = idx_r + IDX_ONE;
                end
            end else begin
                ncnt_s = cnt_r + CNT_ONE;
            end
        end else begin
            ncnt_s = CNT_ZERO;
        end
    end

    // State and output registers; en=0 blanks the lines and freezes index/dwell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r  <= IDX_ZERO;
            cnt_r  <= CNT_ZERO;
            y_r    <= INACTIVE;
            wrap_r <= 1'b0;
        end else if (en) begin
            idx_r  <= nidx_s;
            cnt_r  <= ncnt_s;
            y_r    <= decode_line(nidx_s);
            wrap_r <= nwrap_s;
        end else begin
            y_r    <= INACTIVE;
            wrap_r <= 1'b0;
        end
    end

    assign y    = y_r;
    assign idx  = idx_r;
    assign wrap = wrap_r;

endmodule

// File: tb/tb_decoder_scan_n.sv
// Directed self-checking bench for decoder_scan_n across three parameter sets.
module tb_decoder_scan_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // DUT0: N=4, DWELL=3, active high
    logic        rst0, en0, mode0, sv0, wrap0;
    logic [3:0]  sel0, last0, idx0;
    logic [15:0] y0;
    // DUT1: N=4, DWELL=3, active low
    logic        rst1, en1, mode1, sv1, wrap1;
    logic [3:0]  sel1, last1, idx1;
    logic [15:0] y1;
    // DUT2: N=2, DWELL=1, active high
    logic        rst2, en2, mode2, sv2, wrap2;
    logic [1:0]  sel2, last2, idx2;
    logic [3:0]  y2;

    decoder_scan_n #(.N(4), .DWELL(3), .ACTIVE_LOW(0)) u0 (
        .clk(clk), .rst(rst0), .en(en0), .mode(mode0), .sel(sel0), .sel_valid(sv0),
        .last(last0), .y(y0), .idx(idx0), .wrap(wrap0));
    decoder_scan_n #(.N(4), .DWELL(3), .ACTIVE_LOW(1)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .sel(sel1), .sel_valid(sv1),
        .last(last1), .y(y1), .idx(idx1), .wrap(wrap1));
    decoder_scan_n #(.N(2), .DWELL(1), .ACTIVE_LOW(0)) u2 (
        .clk(clk), .rst(rst2), .en(en2), .mode(mode2), .sel(sel2), .sel_valid(sv2),
        .last(last2), .y(y2), .idx(idx2), .wrap(wrap2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (y0 !== 16'h0000 || idx0 !== 4'd0 || wrap0 !== 1'b0) begin
            $display("FAIL reset0 y=%h idx=%0d wrap=%b exp y=0000 idx=0 wrap=0", y0, idx0, wrap0);
            failures++;
        end
        checks++;
        if (y1 !== 16'hFFFF || idx1 !== 4'd0 || wrap1 !== 1'b0) begin
            $display("FAIL reset1 y=%h idx=%0d wrap=%b exp y=ffff idx=0 wrap=0", y1, idx1, wrap1);
            failures++;
        end
        tick();
        rst0 = 1'b0;
        tick();
        checks++;
        if (y0 !== 16'h0000 || idx0 !== 4'd0) begin
            $display("FAIL reset_idle y=%h idx=%0d exp y=0000 idx=0", y0, idx0);
            failures++;
        end
    endtask

    task automatic test_direct();
        logic [15:0] e;
        en0 = 1'b1; mode0 = 1'b0; sv0 = 1'b1; sel0 = 4'd5;
        tick();
        checks++;
        if (y0 !== 16'h0020 || idx0 !== 4'd5) begin
            $display("FAIL direct5 y=%h idx=%0d exp y=0020 idx=5", y0, idx0);
            failures++;
        end
        for (int i = 0; i < 16; i++) begin
            sel0 = 4'(i);
            tick();
            e = 16'h0001 << i;
            checks++;
            if (y0 !== e || idx0 !== 4'(i) || wrap0 !== 1'b0) begin
                $display("FAIL sweep%0d y=%h idx=%0d wrap=%b exp y=%h idx=%0d", i, y0, idx0, wrap0, e, i);
                failures++;
            end
        end
    endtask

    task automatic test_scan_wrap();
        logic [15:0] e;
        logic        ew;
        mode0 = 1'b1; last0 = 4'd3; sel0 = 4'd0; sv0 = 1'b1;
        tick();
        sv0 = 1'b0;
        checks++;
        if (y0 !== 16'h0001 || idx0 !== 4'd0) begin
            $display("FAIL scan_start y=%h idx=%0d exp y=0001 idx=0", y0, idx0);
            failures++;
        end
        for (int k = 1; k <= 13; k++) begin
            tick();
            e  = 16'h0001 << ((k / 3) % 4);
            ew = (k == 12);
            checks++;
            if (y0 !== e || wrap0 !== ew) begin
                $display("FAIL scan_k%0d y=%h wrap=%b exp y=%h wrap=%b", k, y0, wrap0, e, ew);
                failures++;
            end
        end
    endtask

    task automatic test_enable_freeze();
        sel0 = 4'd2; sv0 = 1'b1;
        tick();
        sv0 = 1'b0;
        en0 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            sv0 = (k == 2);
            sel0 = 4'd7;
            tick();
            checks++;
            if (y0 !== 16'h0000 || wrap0 !== 1'b0 || idx0 !== 4'd2) begin
                $display("FAIL freeze%0d y=%h wrap=%b idx=%0d exp y=0000 wrap=0 idx=2", k, y0, wrap0, idx0);
                failures++;
            end
        end
        sv0 = 1'b0;
        en0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (y0 !== ((k < 2) ? 16'h0004 : 16'h0008)) begin
                $display("FAIL resume%0d y=%h exp y=%h", k, y0, (k < 2) ? 16'h0004 : 16'h0008);
                failures++;
            end
        end
    endtask

    task automatic test_jump_shrink();
        last0 = 4'd15; sel0 = 4'd9; sv0 = 1'b1;
        tick();
        sv0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (y0 !== 16'h0200 || idx0 !== 4'd9) begin
                $display("FAIL jump%0d y=%h idx=%0d exp y=0200 idx=9", k, y0, idx0);
                failures++;
            end
            if (k < 2) tick();
        end
        last0 = 4'd4;
        tick();
        checks++;
        if (y0 !== 16'h0001 || idx0 !== 4'd0 || wrap0 !== 1'b1) begin
            $display("FAIL shrink y=%h idx=%0d wrap=%b exp y=0001 idx=0 wrap=1", y0, idx0, wrap0);
            failures++;
        end
        // Mode 1->0 holds the line; 0->1 restarts dwell from zero.
        mode0 = 1'b0;
        tick(); tick();
        checks++;
        if (idx0 !== 4'd0 || wrap0 !== 1'b0 || y0 !== 16'h0001) begin
            $display("FAIL mode_hold y=%h idx=%0d wrap=%b exp y=0001 idx=0 wrap=0", y0, idx0, wrap0);
            failures++;
        end
        mode0 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++;
            if (idx0 !== ((k < 3) ? 4'd0 : 4'd1)) begin
                $display("FAIL mode_restart%0d idx=%0d exp idx=%0d", k, idx0, (k < 3) ? 0 : 1);
                failures++;
            end
        end
    endtask

    task automatic test_last_zero();
        last0 = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (wrap0 !== (k % 3 == 0) || ((k >= 3) && y0 !== 16'h0001)) begin
                $display("FAIL last0_k%0d y=%h wrap=%b exp wrap=%b", k, y0, wrap0, (k % 3 == 0));
                failures++;
            end
        end
    endtask

    task automatic test_polarity_async_reset();
        rst1 = 1'b0; en1 = 1'b1; mode1 = 1'b0; sv1 = 1'b1; sel1 = 4'd15; last1 = 4'd3;
        tick();
        checks++;
        if (y1 !== 16'h7FFF || idx1 !== 4'd15) begin
            $display("FAIL pol15 y=%h idx=%0d exp y=7fff idx=15", y1, idx1);
            failures++;
        end
        sel1 = 4'd3;
        tick();
        checks++;
        if (y1 !== 16'hFFF7 || idx1 !== 4'd3) begin
            $display("FAIL pol3 y=%h idx=%0d exp y=fff7 idx=3", y1, idx1);
            failures++;
        end
        sv1 = 1'b0; mode1 = 1'b1;
        #2;
        rst1 = 1'b1;
        #1;
        checks++;
        if (y1 !== 16'hFFFF || idx1 !== 4'd0 || wrap1 !== 1'b0) begin
            $display("FAIL async_rst y=%h idx=%0d wrap=%b exp y=ffff idx=0 wrap=0", y1, idx1, wrap1);
            failures++;
        end
        tick();
        rst1 = 1'b0;
        tick();
        checks++;
        if (y1 !== 16'hFFFE || idx1 !== 4'd0) begin
            $display("FAIL rst_resume0 y=%h idx=%0d exp y=fffe idx=0", y1, idx1);
            failures++;
        end
        tick(); tick();
        checks++;
        if (y1 !== 16'hFFFD || idx1 !== 4'd1) begin
            $display("FAIL rst_resume1 y=%h idx=%0d exp y=fffd idx=1", y1, idx1);
            failures++;
        end
    endtask

    task automatic test_param_sweep();
        logic [3:0] e;
        rst2 = 1'b0; en2 = 1'b1; mode2 = 1'b1; sv2 = 1'b0; sel2 = 2'd0; last2 = 2'd3;
        for (int k = 1; k <= 8; k++) begin
            tick();
            e = 4'b0001 << (k % 4);
            checks++;
            if (y2 !== e || idx2 !== 2'(k % 4) || wrap2 !== (k % 4 == 0)) begin
                $display("FAIL n2_k%0d y=%b idx=%0d wrap=%b exp y=%b idx=%0d wrap=%b",
                         k, y2, idx2, wrap2, e, k % 4, (k % 4 == 0));
                failures++;
            end
        end
    endtask

    initial begin
        rst0 = 1'b1; en0 = 1'b0; mode0 = 1'b0; sv0 = 1'b0; sel0 = 4'd0; last0 = 4'd0;
        rst1 = 1'b1; en1 = 1'b0; mode1 = 1'b0; sv1 = 1'b0; sel1 = 4'd0; last1 = 4'd0;
        rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; sv2 = 1'b0; sel2 = 2'd0; last2 = 2'd0;
        test_reset();
        test_direct();
        test_scan_wrap();
        test_enable_freeze();
        test_jump_shrink();
        test_last_zero();
        test_polarity_async_reset();
        test_param_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with two modes: direct decode of a select input, or auto-scan of the active output line.
- Auto-scan walks the line through 0..last with a programmable dwell time per line.
- Drives strobed loads: display digit/row scanning, bank enables, round-robin selects.
- Adds enable gating, output polarity control and a wrap indication.

Parameters:
N, 4, select width; output width is 2^N (N >= 1)
DWELL, 4, clock cycles each line stays active in scan mode (DWELL >= 1)
ACTIVE_LOW, 0, 0: active line = 1, others 0; 1: active line = 0, others 1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active high
en  input  1  1: output active; 0: all lines inactive, state frozen
mode  input  1  0: direct decode; 1: auto-scan
sel  input  N  line index to load
sel_valid  input  1  load sel into the index register this cycle
last  input  N  highest index visited in scan mode
y  output  2^N  decoded one-hot (or one-cold) lines, registered
idx  output  N  current index register
wrap  output  1  one-cycle pulse when scan wraps from last to 0

Behaviour:
- Reset (async, rst=1), held until first clk edge with rst=0:
  - idx=0, dwell counter=0, wrap=0.
  - y = all inactive: all 0, or all 1 when ACTIVE_LOW=1.
- All state is registered; y is a register, not a combinational decode of idx.
- Next-index (nidx) rules, evaluated only when en=1 (priority order):
  1. sel_valid=1: nidx=sel, dwell counter <= 0, no wrap. Applies in either mode.
  2. mode=1 and dwell counter = DWELL-1:
     - If idx >= last: nidx=0 and wrap <= 1.
     - Otherwise: nidx=idx+1.
     - Dwell counter <= 0.
  3. mode=1 otherwise: nidx=idx, dwell counter <= counter+1.
  4. mode=0 without sel_valid: nidx=idx, dwell counter held at 0.
- Register updates at each edge when en=1:
  - idx <= nidx.
  - y <= line nidx active, all others inactive.
- Latency: sel sampled at edge k appears on y and idx at edge k (visible in cycle k+1). One cycle, no combinational path from sel to y.
- wrap is 1 only in the cycle after the wrapping edge; otherwise 0.
- en=0:
  - At next edge, y <= all inactive and wrap <= 0.
  - idx and dwell counter frozen; sel_valid ignored.
- en returning to 1:
  - Next edge applies the normal rules from the frozen idx and dwell count.
  - y shows the resulting line; no skipped or repeated dwell cycles other than the frozen ones.
- Mode 0->1: scan starts from the current idx with the dwell counter at 0. The first advance occurs DWELL edges after the switch.
- Mode 1->0: the line holds at the current idx until sel_valid. Dwell counter clears to 0.
- last changed while scanning:
  - Takes effect at the next advance decision.
  - If idx > last, the next advance wraps to 0 (with wrap pulse) rather than running up to 2^N-1.
- last = 0: scan stays on line 0 and wrap pulses every DWELL cycles.
- last = 2^N-1: full sweep; idx+1 never overflows because the wrap check happens first.
- DWELL=1: dwell counter is degenerate (always 0) and scan advances every enabled edge.
- Dwell counter width: clog2(DWELL), minimum 1 bit.
- Reset mid-scan: immediate return to reset values regardless of clk; scanning resumes from 0 after rst deasserts, if mode=1 and en=1.

Test Plan:
- Reset + direct decode: N=4, ACTIVE_LOW=0. rst high -> y=16'h0000, idx=0. Release rst; en=1, mode=0, sel_valid=1 with sel=5 -> next cycle y=16'h0020, idx=5. Sweep sel 0..15 -> y=1<<sel each cycle, exactly one bit set.
- Auto-scan with wrap: N=4, DWELL=3, last=3, en=1, mode=1 from idx=0 -> y holds 16'h0001 for 3 cycles, then 16'h0002, 16'h0004, 16'h0008 for 3 cycles each, then 16'h0001 with wrap=1 for exactly one cycle. Period is 12 cycles.
- Enable freeze: mid-scan at idx=2 after 1 dwell cycle, en=0 for 5 cycles -> y=16'h0000, wrap=0, idx=2. en=1 -> line 2 shown for the remaining 2 dwell cycles, then line 3.
- Jump and last shrink during scan: scanning last=15, sel_valid with sel=9 -> idx=9, dwell restarts. Then set last=4 -> at next advance idx=0, wrap=1, y=16'h0001.
- Polarity and async reset: ACTIVE_LOW=1, mode=0, sel=15 -> y=16'h7FFF. Assert rst between clock edges -> y=16'hFFFF and idx=0 immediately, before the next edge.
- Parameter sweep: N=2, DWELL=1, last=3, mode=1 -> y cycles 4'b0001, 0010, 0100, 1000 every cycle, with wrap on each return to 4'b0001.
